// File: rtl/uart_baud_ctrl_if.sv
// rtl/uart_baud_ctrl_if.sv - rate-change request channel for uart_baud_ctrl
// cfg_custom/cfg_custom_inc exist only when UART_BAUD_CUSTOM_EN is defined.
interface uart_baud_ctrl_if #(
    parameter int PHASE_WIDTH = 32
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [2:0]             cfg_baud_sel;
`ifdef UART_BAUD_CUSTOM_EN
    logic                   cfg_custom;
    logic [PHASE_WIDTH-1:0] cfg_custom_inc;
`endif

    modport master (
        output cfg_valid,
        output cfg_baud_sel,
`ifdef UART_BAUD_CUSTOM_EN
        output cfg_custom,
        output cfg_custom_inc,
`endif
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_baud_sel,
`ifdef UART_BAUD_CUSTOM_EN
        input  cfg_custom,
        input  cfg_custom_inc,
`endif
        output cfg_ready
    );
endinterface

// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - DDS baud select, idle-gated rate change with flush, 16x tick
// Optional raw-increment requests are enabled by defining UART_BAUD_CUSTOM_EN.
module uart_baud_ctrl #(
    parameter int          PHASE_WIDTH   = 32,
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter logic [2:0]  DEFAULT_SEL   = 3'd4,
    parameter int unsigned FLUSH_CYCLES  = 4,
    parameter int unsigned QUIET_TIMEOUT = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    uart_baud_ctrl_if.slave        cfg,
    input  logic                   rx_busy_i,
    input  logic                   tx_busy_i,
    output logic [PHASE_WIDTH-1:0] phase_increment_o,
    output logic                   dds_rst_n_o,
    input  logic                   dds_clk_i,
    output logic                   baud_tick_o,
    output logic                   baud_locked_o,
    output logic                   cfg_err_o
);
    typedef logic [PHASE_WIDTH-1:0] inc_t;

    function automatic inc_t calc_inc(input longint unsigned baud);
        longint unsigned num;
        num = (baud * 64'(OVERSAMPLE)) << PHASE_WIDTH;
        return inc_t'((num + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ));
    endfunction

    localparam inc_t INC_TABLE [8] = '{
        calc_inc(64'd9600),   calc_inc(64'd19200),  calc_inc(64'd38400),  calc_inc(64'd57600),
        calc_inc(64'd115200), calc_inc(64'd230400), calc_inc(64'd460800), calc_inc(64'd921600)
    };
    localparam inc_t DEFAULT_INC = INC_TABLE[DEFAULT_SEL];

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int WCW = $clog2(QUIET_TIMEOUT + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
    localparam logic [WCW-1:0] QUIET_LAST = WCW'(QUIET_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_FLUSH      = 2'd0,
        ST_RUN        = 2'd1,
        ST_WAIT_QUIET = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    inc_t           inc_q, inc_d;
    inc_t           pend_q, pend_d;
    logic           err_q, err_d;
    logic           dds_clk_q, tick_q, tick_d, locked_q;
    logic           ready;
    inc_t           req_inc;
    logic           req_ok;

    // Tick rate must stay below clk/2, so the top bit of the increment must be clear.
    always_comb begin
        req_inc = INC_TABLE[cfg.cfg_baud_sel];
`ifdef UART_BAUD_CUSTOM_EN
        if (cfg.cfg_custom) begin
            req_inc = cfg.cfg_custom_inc;
        end
`endif
        req_ok = (req_inc != '0) && !req_inc[PHASE_WIDTH-1];
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        inc_d       = inc_q;
        pend_d      = pend_q;
        err_d       = 1'b0;
        ready       = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
                if (cfg.cfg_valid) begin
                    if (req_ok) begin
                        pend_d     = req_inc;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT_QUIET;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_QUIET: begin
                if (!rx_busy_i && !tx_busy_i) begin
                    inc_d       = pend_q;
                    flush_cnt_d = '0;
                    state_d     = ST_FLUSH;
                end else if (wait_cnt_q == QUIET_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_FLUSH;
        endcase
        tick_d = dds_clk_i & ~dds_clk_q & (state_q != ST_FLUSH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            inc_q       <= DEFAULT_INC;
            pend_q      <= '0;
            err_q       <= 1'b0;
            dds_clk_q   <= 1'b0;
            tick_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            inc_q       <= inc_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            dds_clk_q   <= (state_q == ST_FLUSH) ? 1'b0 : dds_clk_i;
            tick_q      <= tick_d;
            locked_q    <= (state_q == ST_FLUSH) ? 1'b0 : (locked_q | tick_d);
        end
    end

    // Gating by dds_rst_n hides a tick or lock registered on the edge that entered FLUSH.
    assign cfg.cfg_ready         = ready;
    assign phase_increment_o     = inc_q;
    assign dds_rst_n_o           = (state_q != ST_FLUSH);
    assign baud_tick_o           = tick_q & dds_rst_n_o;
    assign baud_locked_o         = locked_q & dds_rst_n_o;
    assign cfg_err_o             = err_q;
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb/tb_uart_baud_ctrl.sv - self-checking bench for uart_baud_ctrl (reference model plus directed checks)
module tb_uart_baud_ctrl;
    localparam int PW    = 32;
    localparam int FLUSH = 4;
    localparam int QT_A  = 65535;
    localparam int QT_B  = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_busy = 1'b0, tx_busy = 1'b0, busy_b = 1'b0;

    logic [PW-1:0] phase_a, phase_b;
    logic dds_rst_n_a, tick_a, locked_a, err_a;
    logic dds_rst_n_b, tick_b, locked_b, err_b;
    logic [PW-1:0] acc_a = '0;
    logic dds_clk_a, dds_clk_b;

    uart_baud_ctrl_if #(.PHASE_WIDTH(PW)) cfg_a ();
    uart_baud_ctrl_if #(.PHASE_WIDTH(PW)) cfg_b ();

    uart_baud_ctrl #(.PHASE_WIDTH(PW), .QUIET_TIMEOUT(QT_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .cfg(cfg_a), .rx_busy_i(rx_busy), .tx_busy_i(tx_busy),
        .phase_increment_o(phase_a), .dds_rst_n_o(dds_rst_n_a), .dds_clk_i(dds_clk_a),
        .baud_tick_o(tick_a), .baud_locked_o(locked_a), .cfg_err_o(err_a)
    );

    uart_baud_ctrl #(.PHASE_WIDTH(PW), .QUIET_TIMEOUT(QT_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .cfg(cfg_b), .rx_busy_i(busy_b), .tx_busy_i(1'b0),
        .phase_increment_o(phase_b), .dds_rst_n_o(dds_rst_n_b), .dds_clk_i(dds_clk_b),
        .baud_tick_o(tick_b), .baud_locked_o(locked_b), .cfg_err_o(err_b)
    );

    always #5 clk = ~clk;

    // Phase-accumulator DDS that dut_a steers; its MSB is the DDS output clock.
    always_ff @(posedge clk) begin
        if (!dds_rst_n_a) acc_a <= '0;
        else              acc_a <= acc_a + phase_a;
    end
    assign dds_clk_a = acc_a[PW-1];
    assign dds_clk_b = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    function automatic logic [31:0] model_inc(input logic [2:0] sel);
        real    baud;
        longint r;
        case (sel)
            3'd0:    baud = 9600.0;
            3'd1:    baud = 19200.0;
            3'd2:    baud = 38400.0;
            3'd3:    baud = 57600.0;
            3'd4:    baud = 115200.0;
            3'd5:    baud = 230400.0;
            3'd6:    baud = 460800.0;
            default: baud = 921600.0;
        endcase
        r = longint'(baud * 16.0 * 4294967296.0 / 50.0e6);
        return r[31:0];
    endfunction

    // Reference model: rate, flush window, pending request and DDS phase in plain counters.
    logic [31:0] m_inc, m_pend, m_acc, m_req;
    int          m_flush_left, m_busy;
    bit          m_wait, m_tick, m_lock, m_err, m_prev, m_live, m_was_flush, m_msb;

    initial begin
        m_live = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_inc = model_inc(3'd4); m_pend = '0; m_acc = '0; m_flush_left = FLUSH;
                m_busy = 0; m_wait = 0; m_tick = 0; m_lock = 0; m_err = 0; m_prev = 0; m_live = 1;
            end else begin
                m_was_flush = (m_flush_left > 0);
                m_msb  = m_acc[31];
                m_tick = m_msb && !m_prev && !m_was_flush;
                m_prev = m_was_flush ? 1'b0 : m_msb;
                m_lock = m_was_flush ? 1'b0 : (m_lock | m_tick);
                m_acc  = m_was_flush ? 32'd0 : m_acc + m_inc;
                m_err  = 0;
                if (m_was_flush) begin
                    m_flush_left--;
                end else if (m_wait) begin
                    if (!rx_busy && !tx_busy) begin
                        m_inc = m_pend; m_flush_left = FLUSH; m_wait = 0;
                    end else begin
                        m_busy++;
                        if (m_busy == QT_A) begin m_err = 1; m_wait = 0; end
                    end
                end else if (cfg_a.cfg_valid) begin
                    m_req = model_inc(cfg_a.cfg_baud_sel);
`ifdef UART_BAUD_CUSTOM_EN
                    if (cfg_a.cfg_custom) m_req = cfg_a.cfg_custom_inc;
`endif
                    if (m_req != 0 && !m_req[31]) begin
                        m_pend = m_req; m_wait = 1; m_busy = 0;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("model phase_increment", phase_a, m_inc);
                chk("model dds_rst_n", dds_rst_n_a, m_flush_left == 0);
                chk("model cfg_ready", cfg_a.cfg_ready, (m_flush_left == 0) && !m_wait);
                chk("model baud_tick", tick_a, m_tick && (m_flush_left == 0));
                chk("model baud_locked", locked_a, m_lock && (m_flush_left == 0));
                chk("model cfg_err", err_a, m_err);
            end
        end
    end

    task automatic req_a(input logic [2:0] sel, input bit custom, input logic [31:0] cinc);
        int k = 0;
        while (!cfg_a.cfg_ready && k < 2000) begin @(negedge clk); k++; end
        chk("ready before request", cfg_a.cfg_ready, 1);
        cfg_a.cfg_valid    = 1'b1;
        cfg_a.cfg_baud_sel = sel;
`ifdef UART_BAUD_CUSTOM_EN
        cfg_a.cfg_custom     = custom;
        cfg_a.cfg_custom_inc = cinc;
`else
        if (custom || cinc != 0) $display("custom request ignored in this build");
`endif
        @(negedge clk);
        cfg_a.cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input string name, input int budget);
        int n = 0;
        while (!tick_a && n < budget) begin @(negedge clk); n++; end
        chk(name, tick_a, 1);
    endtask

    task automatic spacing(input string name, input int lo, input int hi, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!tick_a && n < hi + 5);
            chk_rng(name, n, lo, hi);
        end
    endtask

    task automatic wait_low(input string name, input int budget);
        int k = 0;
        while (dds_rst_n_a && k < budget) begin @(negedge clk); k++; end
        chk(name, dds_rst_n_a, 0);
    endtask

    task automatic count_low(input string name);
        int c = 0;
        while (!dds_rst_n_a && c < 50) begin c++; @(negedge clk); end
        chk(name, c, FLUSH);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_hi, ticks, k;
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_baud_sel = 3'd0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_baud_sel = 3'd0;
`ifdef UART_BAUD_CUSTOM_EN
        cfg_a.cfg_custom = 1'b0; cfg_a.cfg_custom_inc = '0;
        cfg_b.cfg_custom = 1'b0; cfg_b.cfg_custom_inc = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset phase_increment", phase_a, 158329674);
        chk("reset dds_rst_n", dds_rst_n_a, 0);
        chk("reset cfg_ready", cfg_a.cfg_ready, 0);
        chk("reset baud_tick", tick_a, 0);
        chk("reset baud_locked", locked_a, 0);
        chk("reset cfg_err", err_a, 0);

        rst = 1'b0;
        count_low("flush length after reset");
        chk("unlocked before first tick", locked_a, 0);
        wait_tick("first tick at 115200", 100);
        chk("locked with first tick", locked_a, 1);
        spacing("tick spacing 115200", 27, 28, 5);

        req_a(3'd0, 1'b0, 32'd0);
        wait_low("flush after sel0", 5);
        chk("sel0 increment", phase_a, 13194140);
        chk("lock drops in flush", locked_a, 0);
        count_low("flush length sel0");
        wait_tick("first tick at 9600", 1000);
        chk("relocked at 9600", locked_a, 1);
        spacing("tick spacing 9600", 325, 326, 3);

        rx_busy = 1'b1;
        req_a(3'd7, 1'b0, 32'd0);
        ready_hi = 0; ticks = 0;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin rx_busy = 1'b0; tx_busy = 1'b1; end
            @(negedge clk);
            if (cfg_a.cfg_ready) ready_hi++;
            if (tick_a) ticks++;
        end
        chk("cfg_ready low while busy", ready_hi, 0);
        chk_rng("old-rate ticks while busy", ticks, 1, 2);
        chk("rate held while busy", phase_a, 13194140);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("sel7 applied on first idle", phase_a, 1266637395);
        chk("flush starts on first idle", dds_rst_n_a, 0);
        count_low("flush length sel7");
        wait_tick("first tick at 921600", 20);
        spacing("tick spacing 921600", 3, 4, 4);

        req_a(3'd7, 1'b0, 32'd0);
        wait_low("same-rate request still flushes", 5);
        count_low("flush length same rate");

        rx_busy = 1'b1;
        req_a(3'd0, 1'b0, 32'd0);
        repeat (10) @(negedge clk);
        chk("waiting before reset", cfg_a.cfg_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset mid-wait restores default", phase_a, 158329674);
        count_low("flush length after mid-wait reset");
        rx_busy = 1'b0;
        repeat (20) @(negedge clk);
        chk("pending request dropped", phase_a, 158329674);

`ifdef UART_BAUD_CUSTOM_EN
        req_a(3'd0, 1'b1, 32'h8000_0000);
        chk("custom invalid cfg_err", err_a, 1);
        chk("custom invalid stays ready", cfg_a.cfg_ready, 1);
        k = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (!dds_rst_n_a) k++; end
        chk("custom invalid no flush", k, 0);
        req_a(3'd0, 1'b1, 32'h1000_0000);
        wait_low("custom valid flush", 5);
        chk("custom increment applied", phase_a, 32'h1000_0000);
        wait_tick("first custom tick", 40);
        spacing("custom tick spacing", 16, 16, 3);
`endif

        busy_b = 1'b1;
        k = 0;
        while (!cfg_b.cfg_ready && k < 50) begin @(negedge clk); k++; end
        chk("timeout unit ready", cfg_b.cfg_ready, 1);
        cfg_b.cfg_valid = 1'b1; cfg_b.cfg_baud_sel = 3'd0;
        @(negedge clk);
        cfg_b.cfg_valid = 1'b0;
        chk("timeout unit waiting", cfg_b.cfg_ready, 0);
        k = 0;
        while (!err_b && k < 300) begin @(negedge clk); k++; end
        chk("cfg_err at timeout cycle", k, QT_B);
        chk("timeout keeps old rate", phase_b, 158329674);
        chk("ready again after timeout", cfg_b.cfg_ready, 1);
        chk("timeout does not flush", dds_rst_n_b, 1);
        chk("timeout unit no tick without dds", tick_b, 0);
        chk("timeout unit not locked without dds", locked_b, 0);
        @(negedge clk);
        chk("cfg_err is one cycle", err_b, 0);
        busy_b = 1'b0;

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
